// File: rtl/spu_pkg.sv
// Shared constants and types for the SPU register-file / forwarding slice.
// Vectors use big-endian bit numbering: bit 0 is the MSB.
package spu_pkg;

    localparam int unsigned NUM_REGS  = 128;
    localparam int unsigned DATA_W    = 128;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned FWD_DEPTH = 4;

    typedef logic [0:ADDR_W-1] reg_addr_t;
    typedef logic [0:DATA_W-1] quad_t;

    typedef struct packed {
        quad_t     data;
        reg_addr_t addr;
        logic      en;
    } fwd_tap_t;

endpackage

// File: rtl/spu_operand_select.sv
// Combinational priority resolver for one source operand:
// youngest matching enabled tap, then same-edge write-back, then the array.
module spu_operand_select
    import spu_pkg::*;
(
    input  reg_addr_t                i_addr,
    input  fwd_tap_t [FWD_DEPTH-1:0] i_taps,
    input  logic                     i_wb_en,
    input  reg_addr_t                i_wb_addr,
    input  quad_t                    i_wb_data,
    input  quad_t                    i_arr_data,
    output quad_t                    o_value,
    output logic                     o_hit
);

    always_comb begin
        logic w_tap_found;
        o_value     = i_arr_data;
        o_hit       = 1'b0;
        w_tap_found = 1'b0;
        if (i_wb_en && (i_wb_addr == i_addr)) begin
            o_value = i_wb_data;
            o_hit   = 1'b1;
        end
        // Ascending scan with a found flag so the lowest-index tap wins over wb.
        for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
            if (!w_tap_found && i_taps[k].en && (i_taps[k].addr == i_addr)) begin
                o_value     = i_taps[k].data;
                o_hit       = 1'b1;
                w_tap_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spu_reg_file_fwd.sv
// SPU 128x128-bit register table with write-back port and forwarded,
// registered source operands delivered one cycle after a read request.
module spu_reg_file_fwd
    import spu_pkg::*;
(
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                rd_valid,
    input  logic [0:ADDR_W-1]                   rd_addr_a,
    input  logic [0:ADDR_W-1]                   rd_addr_b,
    input  logic [0:ADDR_W-1]                   rd_addr_c,
    input  logic                                branch_is_taken,
    output logic [0:DATA_W-1]                   src_reg_a,
    output logic [0:DATA_W-1]                   src_reg_b,
    output logic [0:DATA_W-1]                   src_reg_c,
    output logic                                src_valid,
    input  logic [0:DATA_W-1]                   wb_data,
    input  logic [0:ADDR_W-1]                   wb_reg_addr,
    input  logic                                wb_enable_reg_write,
    input  logic [FWD_DEPTH-1:0][0:DATA_W-1]    fwd_data,
    input  logic [FWD_DEPTH-1:0][0:ADDR_W-1]    fwd_addr,
    input  logic [FWD_DEPTH-1:0]                fwd_en,
    output logic [0:2]                          fwd_hit
);

    quad_t                    r_regs [NUM_REGS];
    quad_t                    r_src_a, r_src_b, r_src_c;
    logic                     r_src_valid;
    logic [0:2]               r_fwd_hit;

    fwd_tap_t [FWD_DEPTH-1:0] w_taps;
    quad_t                    w_val_a, w_val_b, w_val_c;
    logic                     w_hit_a, w_hit_b, w_hit_c;

    always_comb begin
        w_taps = '0;
        for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
            w_taps[k].data = fwd_data[k];
            w_taps[k].addr = fwd_addr[k];
            w_taps[k].en   = fwd_en[k];
        end
    end

    spu_operand_select u_sel_a (
        .i_addr     (rd_addr_a),
        .i_taps     (w_taps),
        .i_wb_en    (wb_enable_reg_write),
        .i_wb_addr  (wb_reg_addr),
        .i_wb_data  (wb_data),
        .i_arr_data (r_regs[rd_addr_a]),
        .o_value    (w_val_a),
        .o_hit      (w_hit_a)
    );

    spu_operand_select u_sel_b (
        .i_addr     (rd_addr_b),
        .i_taps     (w_taps),
        .i_wb_en    (wb_enable_reg_write),
        .i_wb_addr  (wb_reg_addr),
        .i_wb_data  (wb_data),
        .i_arr_data (r_regs[rd_addr_b]),
        .o_value    (w_val_b),
        .o_hit      (w_hit_b)
    );

    spu_operand_select u_sel_c (
        .i_addr     (rd_addr_c),
        .i_taps     (w_taps),
        .i_wb_en    (wb_enable_reg_write),
        .i_wb_addr  (wb_reg_addr),
        .i_wb_data  (wb_data),
        .i_arr_data (r_regs[rd_addr_c]),
        .o_value    (w_val_c),
        .o_hit      (w_hit_c)
    );

    // Flop array with async clear; write-back is never gated by a flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_enable_reg_write) begin
            r_regs[wb_reg_addr] <= wb_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_src_a     <= '0;
            r_src_b     <= '0;
            r_src_c     <= '0;
            r_src_valid <= 1'b0;
            r_fwd_hit   <= '0;
        end else if (rd_valid && !branch_is_taken) begin
            r_src_a     <= w_val_a;
            r_src_b     <= w_val_b;
            r_src_c     <= w_val_c;
            r_src_valid <= 1'b1;
            r_fwd_hit   <= {w_hit_a, w_hit_b, w_hit_c};
        end else begin
            r_src_valid <= 1'b0;
        end
    end

    assign src_reg_a = r_src_a;
    assign src_reg_b = r_src_b;
    assign src_reg_c = r_src_c;
    assign src_valid = r_src_valid;
    assign fwd_hit   = r_fwd_hit;

endmodule

// File: doc/spu_reg_file_fwd.md
Name: spu_reg_file_fwd

Overview:
- Register-file/forwarding stage that consumes the execution unit's results.
- Holds the 128 x 128-bit SPU register table and absorbs the unit's write-back port.
- Snoops the unit's in-flight result taps and delivers forwarded source operands (ra, rb, rc) one cycle after a read request.
- Sits between decode and the fixed-point/shift execution pipes; its src outputs drive their src_reg_a/src_reg_b inputs.

Parameters:
- NUM_REGS, 128, number of architectural registers.
- DATA_W, 128, register width in bits (big-endian bit numbering, bit 0 = MSB).
- ADDR_W, 7, register address width.
- FWD_DEPTH, 4, number of in-flight result taps snooped (tap 0 = youngest).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_valid  in  1  read request this cycle.
- rd_addr_a / rd_addr_b / rd_addr_c  in  ADDR_W each  source register addresses.
- branch_is_taken  in  1  flush; kills the request in flight.
- src_reg_a / src_reg_b / src_reg_c  out  DATA_W each  resolved operands, registered.
- src_valid  out  1  src_reg_* valid this cycle.
- wb_data  in  DATA_W  write-back value.
- wb_reg_addr  in  ADDR_W  write-back destination.
- wb_enable_reg_write  in  1  commit wb_data to the table.
- fwd_data  in  FWD_DEPTH x DATA_W  in-flight result taps.
- fwd_addr  in  FWD_DEPTH x ADDR_W  tap destination addresses.
- fwd_en  in  FWD_DEPTH  tap will write the register table.
- fwd_hit  out  3  per-operand flag (a, b, c): value came from a tap or the wb port, not the array.

Behaviour:
- Reset (reset=0, asynchronous):
  - all NUM_REGS entries clear to 0;
  - src_reg_a/b/c = 0, src_valid = 0, fwd_hit = 0.
  - Reset deasserted mid-operation loses any pending request; no output pulse follows.
- Write:
  - On the rising edge with wb_enable_reg_write=1, table[wb_reg_addr] <= wb_data.
  - There is no hardwired-zero register; r0 is writable.
- Read latency: exactly 1 cycle. rd_valid at edge N gives src_valid=1 during cycle N+1, with operands captured at edge N.
- Operand resolution, evaluated per operand at the capture edge in strict priority order:
  1. lowest-index tap k with fwd_en[k]=1 and fwd_addr[k]=addr → fwd_data[k];
  2. wb_enable_reg_write=1 and wb_reg_addr=addr → wb_data (same-edge write bypass);
  3. table[addr] (pre-edge contents).
- fwd_hit bit = 1 iff resolution rule 1 or 2 applied for that operand.
- Taps with fwd_en=0 are ignored even if the address matches.
- Duplicate addresses across a/b/c resolve independently to the same value.
- Flush:
  - branch_is_taken=1 at the capture edge: src_valid <= 0, src_reg_* and fwd_hit hold their previous values.
  - Writes still commit; write-back is never flushed here.
- rd_valid=0: src_valid <= 0, operands hold.
- Read/write collision on the same address always returns the new value (rule 2); no read-before-write path exists.
- The array is purely flop-based with no reset-free RAM, so the async clear is honoured.

Decomposition:
- Shared package spu_pkg:
  - constants: NUM_REGS, DATA_W, ADDR_W, FWD_DEPTH;
  - types: typedef reg_addr_t (logic [0:ADDR_W-1]), typedef quad_t (logic [0:DATA_W-1]);
  - typedef fwd_tap_t: struct of data, addr, en.
- One sub-module, spu_operand_select: combinational priority mux for a single operand. It takes addr, the taps, the wb port and the array value, and returns value + hit. It is instantiated three times; the top module holds the array and output registers.

Test Plan:
- Reset: write 0xAAAA..AA to r5, pulse reset low mid-cycle → src outputs drop to 0 immediately; next read of r5 returns 0, src_valid rises only after a new rd_valid.
- Plain read: write r10=0x0123_4567_89AB_CDEF_0011_2233_4455_6677, later rd_addr_a=10 → next cycle src_reg_a equals it, fwd_hit=000, src_valid=1.
- Bypass: same edge wb_reg_addr=20, wb_data=0xFFFF..FF, rd_addr_b=20 → src_reg_b=0xFFFF..FF, fwd_hit=010.
- Tap priority: fwd tap0 (addr 7, data 0x1), tap2 (addr 7, data 0x2), wb (addr 7, data 0x3), all enabled, rd_addr_c=7 → src_reg_c=0x1. With fwd_en[0]=0 → 0x2.
- Flush: rd_valid=1 with branch_is_taken=1 → src_valid=0 next cycle, operands unchanged; a concurrent wb to r3 still commits and a later read returns it.
- Back-to-back: rd_valid held high 4 cycles with addresses 1,2,3,4 on port a and r1–r4 preloaded 0x11,0x22,0x33,0x44 → src_reg_a sequence 0x11,0x22,0x33,0x44 with src_valid continuously 1.
